// File: rtl/alu_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue controller that sits between an instruction source and an external
// 8-bit combinational ALU. It takes one 16-bit instruction word and decodes it.
// It reads the operands from a 4x8 register file and drives the ALU for exactly
// one cycle. It then writes the result back and returns it to the consumer.
// Throughput is one instruction every three cycles.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   instr[15:0]           {op[15:13], rd[12:11], rs1[10:9], rs2[8:7],
//                          imm_sel[6], imm[5:0]}
//   instr_valid/ready     instruction handshake (ready depends only on state)
//   alu_en/op/src1/src2   registered drive to the ALU, active in EXEC only
//   alu_dst, alu_zero     ALU result and zero flag, valid in the same cycle
//   res_data/zero/valid   written-back result, held until res_ready
//   res_ready             consumer accepts the result
//   retired[CNT_W-1:0]    count of completed result handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic              alu_en,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   input  logic [DATA_W-1:0] alu_dst,
   input  logic              alu_zero,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zero,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic [1:0]        rd_q, rd_d;
   logic              instr_ready_q, instr_ready_d;
   logic              alu_en_q, alu_en_d;
   logic [2:0]        alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_src1_q, alu_src1_d;
   logic [DATA_W-1:0] alu_src2_q, alu_src2_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_zero_q, res_zero_d;
   logic              res_valid_q, res_valid_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   // Instruction field decode
   logic [2:0] dec_op_s;
   logic [1:0] dec_rd_s;
   logic [1:0] dec_rs1_s;
   logic [1:0] dec_rs2_s;
   logic       dec_imm_sel_s;
   logic [5:0] dec_imm_s;

   assign dec_op_s      = instr[15:13];
   assign dec_rd_s      = instr[12:11];
   assign dec_rs1_s     = instr[10:9];
   assign dec_rs2_s     = instr[8:7];
   assign dec_imm_sel_s = instr[6];
   assign dec_imm_s     = instr[5:0];

   // Next-state and datapath computation for the IDLE -> EXEC -> RESP loop
   always_comb begin
      state_d       = state_q;
      regs_d        = regs_q;
      rd_d          = rd_q;
      instr_ready_d = instr_ready_q;
      alu_en_d      = alu_en_q;
      alu_op_d      = alu_op_q;
      alu_src1_d    = alu_src1_q;
      alu_src2_d    = alu_src2_q;
      res_data_d    = res_data_q;
      res_zero_d    = res_zero_q;
      res_valid_d   = res_valid_q;
      retired_d     = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid && instr_ready_q) begin
               // The register file only changes at the end of EXEC. Sampling
               // the operands at the accept edge therefore gives the same
               // values as reading them in EXEC, and the ALU drive can come
               // straight from flops.
               state_d       = ST_EXEC;
               rd_d          = dec_rd_s;
               instr_ready_d = 1'b0;
               alu_en_d      = 1'b1;
               alu_op_d      = dec_op_s;
               alu_src1_d    = regs_q[dec_rs1_s];
               if (dec_imm_sel_s) begin
                  alu_src2_d = {{(DATA_W-6){1'b0}}, dec_imm_s};
               end else begin
                  alu_src2_d = regs_q[dec_rs2_s];
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            // The ALU result is combinational, so it is captured at the closing edge
            regs_d[rd_q] = alu_dst;
            res_data_d   = alu_dst;
            res_zero_d   = alu_zero;
            res_valid_d  = 1'b1;
            alu_en_d     = 1'b0;
            alu_op_d     = 3'd0;
            alu_src1_d   = {DATA_W{1'b0}};
            alu_src2_d   = {DATA_W{1'b0}};
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (res_ready) begin
               res_valid_d   = 1'b0;
               retired_d     = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
               instr_ready_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            // Unreachable encoding: recover to an idle, result-free state
            state_d       = ST_IDLE;
            instr_ready_d = 1'b1;
            alu_en_d      = 1'b0;
            alu_op_d      = 3'd0;
            alu_src1_d    = {DATA_W{1'b0}};
            alu_src2_d    = {DATA_W{1'b0}};
            res_valid_d   = 1'b0;
         end
      endcase
   end

   // State, register file and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         rd_q          <= 2'd0;
         instr_ready_q <= 1'b1;
         alu_en_q      <= 1'b0;
         alu_op_q      <= 3'd0;
         alu_src1_q    <= {DATA_W{1'b0}};
         alu_src2_q    <= {DATA_W{1'b0}};
         res_data_q    <= {DATA_W{1'b0}};
         res_zero_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         retired_q     <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         rd_q          <= rd_d;
         instr_ready_q <= instr_ready_d;
         alu_en_q      <= alu_en_d;
         alu_op_q      <= alu_op_d;
         alu_src1_q    <= alu_src1_d;
         alu_src2_q    <= alu_src2_d;
         res_data_q    <= res_data_d;
         res_zero_q    <= res_zero_d;
         res_valid_q   <= res_valid_d;
         retired_q     <= retired_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign alu_en      = alu_en_q;
   assign alu_op      = alu_op_q;
   assign alu_src1    = alu_src1_q;
   assign alu_src2    = alu_src2_q;
   assign res_data    = res_data_q;
   assign res_zero    = res_zero_q;
   assign res_valid   = res_valid_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU attached.
// Stimulus pushes hand-computed results into a queue. A monitor pops the queue
// and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_NOT = 3'd7;

   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       instr;
   logic              instr_valid;
   logic              instr_ready;
   logic              alu_en;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [DATA_W-1:0] alu_dst;
   logic              alu_zero;
   logic [DATA_W-1:0] res_data;
   logic              res_zero;
   logic              res_valid;
   logic              res_ready;
   logic [CNT_W-1:0]  retired;

   int total = 0;
   int bad = 0;
   int hs_count = 0;
   int exp_retired = 0;
   logic [8:0] exp_q [$];

   alu_issue_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .alu_en(alu_en), .alu_op(alu_op),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_dst(alu_dst),
      .alu_zero(alu_zero), .res_data(res_data), .res_zero(res_zero),
      .res_valid(res_valid), .res_ready(res_ready), .retired(retired)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 not
   always_comb begin
      case (alu_op)
         3'd0:    alu_dst = alu_src1 + alu_src2;
         3'd1:    alu_dst = alu_src1 - alu_src2;
         3'd2:    alu_dst = alu_src1 & alu_src2;
         3'd3:    alu_dst = alu_src1 | alu_src2;
         3'd4:    alu_dst = alu_src1 ^ alu_src2;
         3'd5:    alu_dst = alu_src1 << 1;
         3'd6:    alu_dst = alu_src1 >> 1;
         default: alu_dst = ~alu_src1;
      endcase
   end
   assign alu_zero = (alu_dst == 8'h00);

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic isel, input logic [5:0] imm);
      return {op, rd, rs1, rs2, isel, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: a result handshake completes at the next rising edge
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h expected none", res_data);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("res_data", {24'd0, res_data}, {24'd0, e[8:1]});
            check("res_zero", {31'd0, res_zero}, {31'd0, e[0]});
         end
      end
   end

   // Issue one instruction from IDLE, check the EXEC drive, optionally stall RESP
   task automatic issue(input logic [15:0] w, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] d, input logic z, input int hold);
      logic [2:0] wop;
      int n;
      wop = w[15:13];
      @(negedge clk);
      check("instr_ready_idle", {31'd0, instr_ready}, 32'd1);
      instr       = w;
      instr_valid = 1'b1;
      res_ready   = 1'b0;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check("exec_alu_en", {31'd0, alu_en}, 32'd1);
      check("exec_alu_op", {29'd0, alu_op}, {29'd0, wop});
      check("exec_alu_src1", {24'd0, alu_src1}, {24'd0, s1});
      check("exec_alu_src2", {24'd0, alu_src2}, {24'd0, s2});
      check("exec_instr_ready", {31'd0, instr_ready}, 32'd0);
      exp_q.push_back({d, z});
      @(posedge clk);
      #1;
      check("resp_res_valid", {31'd0, res_valid}, 32'd1);
      check("resp_alu_en", {31'd0, alu_en}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            instr       = enc(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 6'd63);
            instr_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         check("hold_res_valid", {31'd0, res_valid}, 32'd1);
         check("hold_res_data", {24'd0, res_data}, {24'd0, d});
         check("hold_instr_ready", {31'd0, instr_ready}, 32'd0);
         check("hold_retired", {16'd0, retired}, exp_retired);
         check("hold_alu_en", {31'd0, alu_en}, 32'd0);
      end
      instr_valid = 1'b0;
      res_ready   = 1'b1;
      n = 0;
      while (res_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (res_valid) begin
         total++;
         bad++;
         $display("FAIL result_timeout: got res_valid=1 expected 0 within 10 cycles");
      end
      exp_retired++;
      check("retired", {16'd0, retired}, exp_retired);
      check("instr_ready_after", {31'd0, instr_ready}, 32'd1);
      res_ready = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      instr       = 16'h0000;
      instr_valid = 1'b0;
      res_ready   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_data", {24'd0, res_data}, 32'd0);
      check("rst_res_zero", {31'd0, res_zero}, 32'd0);
      check("rst_retired", {16'd0, retired}, 32'd0);
      check("rst_alu_en", {31'd0, alu_en}, 32'd0);
      check("rst_alu_op", {29'd0, alu_op}, 32'd0);
      check("rst_alu_src1", {24'd0, alu_src1}, 32'd0);
      check("rst_alu_src2", {24'd0, alu_src2}, 32'd0);

      // 1: add R1 = R0 + 5
      issue(enc(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 6'd5), 8'h00, 8'h05, 8'h05, 1'b0, 0);
      // 2: sub R2 = R1 - R1 -> zero
      issue(enc(OP_SUB, 2'd2, 2'd1, 2'd1, 1'b0, 6'd0), 8'h05, 8'h05, 8'h00, 1'b1, 0);
      // 3: shl R1 = R1 << 1 (self-overwrite), then add R3 = R1 + 1
      issue(enc(OP_SHL, 2'd1, 2'd1, 2'd0, 1'b0, 6'd0), 8'h05, 8'h00, 8'h0A, 1'b0, 0);
      issue(enc(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 6'd1), 8'h0A, 8'h01, 8'h0B, 1'b0, 0);
      // 4: add R2 = R3 + R1 with the result stalled for 5 cycles
      issue(enc(OP_ADD, 2'd2, 2'd3, 2'd1, 1'b0, 6'd0), 8'h0B, 8'h0A, 8'h15, 1'b0, 5);
      @(posedge clk);
      #1;
      check("no_latch_while_busy", {31'd0, alu_en}, 32'd0);

      // 5: reset during EXEC of add R0 = R0 + 7 aborts the instruction
      @(negedge clk);
      instr       = enc(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 6'd7);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check("abort_exec_src2", {24'd0, alu_src2}, 32'd7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_retired = 0;
      check("abort_res_valid", {31'd0, res_valid}, 32'd0);
      check("abort_instr_ready", {31'd0, instr_ready}, 32'd1);
      check("abort_retired", {16'd0, retired}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_result", {31'd0, res_valid}, 32'd0);
      issue(enc(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 6'd0), 8'h00, 8'h00, 8'h00, 1'b1, 0);

      // 6: R0 = ~R0 = FF, then R0 = FF + 1 wraps to 0, then R1 = ~R0
      issue(enc(OP_NOT, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0), 8'h00, 8'h00, 8'hFF, 1'b0, 0);
      issue(enc(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 6'd1), 8'hFF, 8'h01, 8'h00, 1'b1, 0);
      issue(enc(OP_NOT, 2'd1, 2'd0, 2'd0, 1'b0, 6'd0), 8'h00, 8'h00, 8'hFF, 1'b0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("handshake_count", hs_count, 32'd9);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so a stuck handshake cannot hang the run
   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish by 100000ns");
      $fatal(1, "timeout");
   end

endmodule
